// File: rtl/pipelined_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_adder_pkg
// Shared definitions for the segmented pipelined adder.
//   DEF_WIDTH / DEF_SEG : default operand width and bits per pipeline stage
//   seg_t               : one SEG-bit operand/sum segment (default SEG)
//   stage_ctl_t         : per-stage valid bit and registered inter-stage carry
//   stages_f()          : number of pipeline stages, WIDTH/SEG (at least 1)
// ---------------------------------------------------------------------------
package pipelined_adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SEG   = 8;

  typedef logic [DEF_SEG-1:0] seg_t;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int unsigned stages_f(input int unsigned width,
                                           input int unsigned seg);
    if (seg == 0 || width < seg) return 1;
    return width / seg;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// Purely combinational SEG-bit ripple-carry adder built from full-adder cells.
// Ports:
//   i_a, i_b  [SEG-1:0]  segment operands
//   i_cin                carry into bit 0 of the segment
//   o_sum     [SEG-1:0]  segment sum
//   o_cout               carry out of the segment MSB
//   o_cmsb               carry into the segment MSB (signed overflow term)
// ---------------------------------------------------------------------------
module adder_slice
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned SEG = DEF_SEG
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_cmsb
);

  logic w_c;

  always_comb begin
    o_sum  = '0;
    o_cmsb = 1'b0;
    w_c    = i_cin;
    for (int unsigned i = 0; i < SEG; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      if (i == SEG - 1) o_cmsb = w_c;
      w_c = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder split into STAGES = WIDTH/SEG ripple segments with the
// carry registered between segments. One operation per cycle, valid/ready
// handshake on both sides, latency STAGES cycles when not stalled.
// Optional build macro: PIPELINED_ADDER_ADDSUB_EN adds the 'sub' input
// (1 = a + ~b + 1, cin ignored).
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  input handshake
//   a, b [WIDTH-1:0]    operands
//   cin                 carry into bit 0
//   sub                 subtract select (only with PIPELINED_ADDER_ADDSUB_EN)
//   out_valid, out_ready output handshake
//   s [WIDTH-1:0]       registered sum modulo 2^WIDTH
//   cout                registered carry out of bit WIDTH-1
//   ovf                 registered signed overflow (carry-in XOR carry-out MSB)
// ---------------------------------------------------------------------------
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_ADDSUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = stages_f(WIDTH, SEG);

  // Global advance: the whole pipeline moves or holds as one.
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage-0 operand conditioning; subtract is folded in here so later
  // stages only ever add.
  logic [WIDTH-1:0] w_b0;
  logic             w_cin0;

  always_comb begin
`ifdef PIPELINED_ADDER_ADDSUB_EN
    w_b0   = sub ? ~b : b;
    w_cin0 = sub ? 1'b1 : cin;
`else
    w_b0   = b;
    w_cin0 = cin;
`endif
  end

  // Per-stage registers. r_a/r_b carry the operands forward so stage k
  // finds its segment at [k*SEG +: SEG]; r_s accumulates the completed
  // lower sum segments so every segment of an operation leaves together.
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  stage_ctl_t       r_ctl [STAGES];
  logic             r_ovf;

  // Values entering each stage (from the ports for stage 0, else from the
  // previous stage registers).
  logic [WIDTH-1:0] w_pa [STAGES];
  logic [WIDTH-1:0] w_pb [STAGES];
  logic [WIDTH-1:0] w_ps [STAGES];
  logic             w_pv [STAGES];
  logic             w_ci [STAGES];

  logic [SEG-1:0]   w_seg [STAGES];
  logic             w_co  [STAGES];
  logic             w_cm  [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_pa[k] = a;
      assign w_pb[k] = w_b0;
      assign w_ps[k] = '0;
      assign w_pv[k] = in_valid;
      assign w_ci[k] = w_cin0;
    end else begin : g_next
      assign w_pa[k] = r_a[k-1];
      assign w_pb[k] = r_b[k-1];
      assign w_ps[k] = r_s[k-1];
      assign w_pv[k] = r_ctl[k-1].valid;
      assign w_ci[k] = r_ctl[k-1].carry;
    end

    adder_slice #(
      .SEG(SEG)
    ) u_slice (
      .i_a    (w_pa[k][k*SEG +: SEG]),
      .i_b    (w_pb[k][k*SEG +: SEG]),
      .i_cin  (w_ci[k]),
      .o_sum  (w_seg[k]),
      .o_cout (w_co[k]),
      .o_cmsb (w_cm[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_ctl[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k]               <= w_pa[k];
        r_b[k]               <= w_pb[k];
        r_s[k]               <= w_ps[k];
        r_s[k][k*SEG +: SEG] <= w_seg[k];
        r_ctl[k].valid       <= w_pv[k];
        r_ctl[k].carry       <= w_co[k];
      end
      r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
    end
  end

  assign out_valid = r_ctl[STAGES-1].valid;
  assign s         = r_s[STAGES-1];
  assign cout      = r_ctl[STAGES-1].carry;
  assign ovf       = r_ovf;

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus a carry-in through a pipeline of SEG-bit ripple segments. Carry is registered between segments.
- Accepts one operation per cycle. Valid/ready handshake with back-pressure on both sides.
- Used as the datapath adder wherever a long combinational carry chain would miss timing.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG (derived, >= 1).

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and cin valid this cycle
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A (unsigned/two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum, modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- sub  input  1  only present with ADDSUB_EN; 1 = subtract

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear; out_valid=0.
  - s, cout and ovf = 0.
  - in_ready=1 from the first cycle after reset release.
  - Reset mid-operation discards all in-flight operations; none is emitted later.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and B with the carry registered by stage k-1; stage 0 uses cin.
- Operand skew:
  - Unconsumed upper operand segments travel forward in per-stage registers.
  - Completed lower sum segments travel forward in delay registers.
  - All segments of one operation leave together.
- Pipeline control:
  - adv = !out_valid || out_ready.
  - Every stage register (data and valid) loads only when adv=1; otherwise all hold.
  - in_ready = adv (combinational from out_valid and out_ready).
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - A bubble (in_valid=0 with adv=1) inserts valid=0 into stage 0.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_valid with no stall.
  - Throughput is 1 operation per cycle while out_ready=1.
  - Each stall cycle adds one cycle of latency to every in-flight operation. No reordering, loss or duplication.
- Outputs are registered: s, cout and ovf are last-stage registers. They are stable and unchanged while out_valid && !out_ready.
- ovf is computed from the MSB full-adder cell of stage STAGES-1 in the same cycle as cout.
- STAGES=1: the block is a single registered WIDTH-bit adder with latency 1.
- Simultaneous output accept and input accept in the same cycle is legal and expected at full throughput.

Optional Feature:
- Macro: PIPELINED_ADDER_ADDSUB_EN
- Defined:
  - Port sub exists and is captured with the operation.
  - sub=1 computes a + ~b + 1: b is inverted and cin is ignored, with 1 forced into stage 0.
  - cout is then the not-borrow flag (1 when a >= b unsigned); ovf is signed subtract overflow.
- Not defined: sub port absent; add only, behaviour exactly as above.

Decomposition:
- Shared package holds:
  - the derived STAGES constant function;
  - a seg_t typedef parametrised via SEG;
  - the stage-valid/data struct used for skew registers.
- One sub-module, adder_slice: purely combinational SEG-bit ripple of full-adder cells. It outputs sum, carry-out and carry-into-MSB (for ovf).
- Instantiated STAGES times by a generate loop; all sequential logic stays in pipelined_adder.

Test Plan:
- Defaults WIDTH=32, SEG=8.
  - Stimulus: a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0, out_ready=1.
  - Response: out_valid 4 cycles later; s=0, cout=1, ovf=0.
  - This covers carry rippling across all stages.
- Signed overflow.
  - Stimulus: a=32'h7FFF_FFFF, b=1, cin=0.
  - Response: s=32'h8000_0000, cout=0, ovf=1.
  - Also a=32'h8000_0000, b=32'h8000_0000 gives s=0, cout=1, ovf=1.
- Streaming under stall.
  - Stimulus: 10 back-to-back operations a=i, b=3*i, cin=i[0]. out_ready is low on cycles 6-8.
  - Response: results i+3i+cin in order, none lost or duplicated; in_ready=0 exactly while out_valid && !out_ready; s is stable during the stall.
- Reset mid-flight.
  - Stimulus: 3 operations issued, then rst_n pulsed low asynchronously between edges.
  - Response: out_valid=0 immediately; no stale results after release; the next operation has latency 4.
- Bubbles.
  - Stimulus: in_valid pattern 1,0,1,0,1.
  - Response: out_valid pattern identical, delayed 4 cycles; the sums match.
- PIPELINED_ADDER_ADDSUB_EN build.
  - Stimulus: sub=1, a=5, b=7.
  - Response: s=32'hFFFF_FFFE, cout=0, ovf=0. With a=7, b=5: s=2, cout=1.
